// File: rtl/stream_range_src_pkg.sv
// Shared definitions for stream_range_src and its output register stage:
// default data/count widths and the controller state encoding.
package stream_range_src_pkg;

    localparam int unsigned DEF_N  = 8;
    localparam int unsigned DEF_CW = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_t;

endpackage

// File: rtl/stream_reg_out.sv
// Output register stage for a valid/ready stream element.
// The (data, valid) pair only changes when the owner loads a new element
// or clears valid, so a stalled element is held stable.
//   clk, nrst : clock, async active-low reset
//   ld        : load ld_data and raise valid
//   ld_data   : element to present
//   clr       : drop valid (ld has priority)
//   data      : registered stream element
//   valid     : registered stream valid
module stream_reg_out
    import stream_range_src_pkg::*;
#(
    parameter int unsigned W = DEF_N
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         ld,
    input  logic [W-1:0] ld_data,
    input  logic         clr,
    output logic [W-1:0] data,
    output logic         valid
);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (ld) begin
            data  <= ld_data;
            valid <= 1'b1;
        end else if (clr) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_range_src.sv
// Arithmetic-range stream producer. Accepts one request (start, count, step),
// emits start, start+step, ... (count elements, N-bit wrap) on a valid/ready
// stream, then offers a completion handshake carrying the next unemitted value.
//   clk, nrst                         : clock, async active-low reset
//   in_valid/in_ready                 : request handshake
//   in_start, in_count, in_step       : request payload
//   sOut, sOut_valid, sOut_ready      : element stream
//   out_valid, out_ready, out_next    : completion handshake and next value
module stream_range_src
    import stream_range_src_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned CW = DEF_CW
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_start,
    input  logic [CW-1:0] in_count,
    input  logic [N-1:0]  in_step,
    output logic [N-1:0]  sOut,
    output logic          sOut_valid,
    input  logic          sOut_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_next
);

    state_t        state_q, state_d;
    logic [N-1:0]  cur_q, step_q;
    logic [CW-1:0] rem_q;

    logic          accept_c, xfer_c, last_c, ld_c, clr_c;
    logic [N-1:0]  nxt_c, ld_data_c;

    // Next value in the sequence, wrapping at 2^N.
    assign nxt_c = cur_q + step_q;

    // Next-state and stream-stage control.
    always_comb begin
        state_d   = state_q;
        ld_c      = 1'b0;
        clr_c     = 1'b0;
        ld_data_c = nxt_c;
        accept_c  = in_valid && in_ready && (state_q == ST_IDLE);
        xfer_c    = (state_q == ST_RUN) && sOut_valid && sOut_ready;
        // Completion is taken at rem==1 so the counter never underflows.
        last_c    = xfer_c && (rem_q == CW'(1));
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (in_count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_RUN;
                        ld_c      = 1'b1;
                        ld_data_c = in_start;
                    end
                end
            end
            ST_RUN: begin
                if (last_c) begin
                    state_d = ST_DONE;
                    clr_c   = 1'b1;
                end else if (xfer_c) begin
                    ld_c = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, handshake flags and sequence registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_next  <= '0;
            cur_q     <= '0;
            step_q    <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == ST_IDLE);
            out_valid <= (state_d == ST_DONE);
            if (accept_c) begin
                cur_q  <= in_start;
                step_q <= in_step;
                rem_q  <= in_count;
                if (in_count == '0) begin
                    out_next <= in_start;
                end
            end else if (xfer_c) begin
                cur_q <= nxt_c;
                rem_q <= rem_q - CW'(1);
                if (last_c) begin
                    out_next <= nxt_c;
                end
            end
        end
    end

    stream_reg_out #(.W(N)) u_reg_out (
        .clk     (clk),
        .nrst    (nrst),
        .ld      (ld_c),
        .ld_data (ld_data_c),
        .clr     (clr_c),
        .data    (sOut),
        .valid   (sOut_valid)
    );

endmodule

// File: tb/tb_stream_range_src.sv
// Self-checking bench for stream_range_src: directed and random requests
// checked against an arithmetic model (element i = start + i*step mod 256).
module tb_stream_range_src;

    logic       clk;
    logic       nrst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_start;
    logic [7:0] in_count;
    logic [7:0] in_step;
    logic [7:0] sOut;
    logic       sOut_valid;
    logic       sOut_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_next;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    int          pat[7]   = '{1, 0, 0, 1, 0, 1, 1};

    stream_range_src #(.N(8), .CW(8)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_start   (in_start),
        .in_count   (in_count),
        .in_step    (in_step),
        .sOut       (sOut),
        .sOut_valid (sOut_valid),
        .sOut_ready (sOut_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_next   (out_next)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned model_elem(input logic [7:0] st, input logic [7:0] stp,
                                               input int unsigned i);
        return (32'(st) + i * 32'(stp)) % 256;
    endfunction

    function automatic logic pick_ready(input int mode, input int unsigned cyc);
        if (mode == 1) return 1'($urandom_range(0, 1));
        if (mode == 2) return (cyc < 7) ? 1'(pat[cyc]) : 1'b1;
        return 1'b1;
    endfunction

    // Present the request and wait (bounded) for the accepting edge.
    task automatic wait_accept(input logic [7:0] st, input logic [7:0] cnt,
                               input logic [7:0] stp, output bit acc);
        logic rdy;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_start = st;
        in_count = cnt;
        in_step  = stp;
        for (int i = 0; i < 64 && !acc; i++) begin
            rdy = in_ready;
            tick();
            if (rdy) acc = 1'b1;
        end
        in_valid = 1'b0;
        check("accept", 32'(acc), 32'd1);
    endtask

    // Full transaction: request, stream drain with ready pattern, completion
    // held for 'hold' cycles (optionally with a competing request raised).
    task automatic do_req(input logic [7:0] st, input logic [7:0] cnt, input logic [7:0] stp,
                          input int mode, input int hold, input bit intrude);
        bit          acc;
        logic        r, pv;
        logic [7:0]  pd;
        int unsigned got, cyc, exp_next;
        exp_next = model_elem(st, stp, 32'(cnt));
        wait_accept(st, cnt, stp, acc);
        if (!acc) return;
        if (cnt == 8'd0) begin
            check("zero_out_valid", 32'(out_valid), 32'd1);
            check("zero_out_next", 32'(out_next), exp_next);
            check("zero_no_elem", 32'(sOut_valid), 32'd0);
        end else begin
            check("first_valid", 32'(sOut_valid), 32'd1);
            check("first_data", 32'(sOut), 32'(st));
        end
        got = 0;
        cyc = 0;
        while (got < 32'(cnt) && cyc < 4000) begin
            r          = pick_ready(mode, cyc);
            sOut_ready = r;
            pv         = sOut_valid;
            pd         = sOut;
            tick();
            cyc++;
            if (pv && r) begin
                check("elem", 32'(pd), model_elem(st, stp, got));
                got++;
                if (got == 32'(cnt)) begin
                    check("done_out_valid", 32'(out_valid), 32'd1);
                    check("done_sout_drop", 32'(sOut_valid), 32'd0);
                    check("done_out_next", 32'(out_next), exp_next);
                end
            end else begin
                check("stall_valid", 32'(sOut_valid), 32'(pv));
                if (pv) check("stall_data", 32'(sOut), 32'(pd));
                check("no_early_done", 32'(out_valid), 32'd0);
            end
        end
        sOut_ready = 1'b0;
        check("xfer_count", got, 32'(cnt));
        if (intrude) begin
            in_valid = 1'b1;
            in_start = 8'd100;
            in_count = 8'd2;
            in_step  = 8'd1;
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_out_next", 32'(out_next), exp_next);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_no_elem", 32'(sOut_valid), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("cpl_out_valid", 32'(out_valid), 32'd0);
        check("cpl_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        bit acc;
        nrst       = 1'b0;
        in_valid   = 1'b0;
        in_start   = '0;
        in_count   = '0;
        in_step    = '0;
        sOut_ready = 1'b0;
        out_ready  = 1'b0;

        // Reset values and in_ready rising on the first edge after release.
        #2;
        check("rst_sout", 32'(sOut), 32'd0);
        check("rst_sout_valid", 32'(sOut_valid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_next", 32'(out_next), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        #10;
        nrst = 1'b1;
        #1;
        check("rel_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        check("rel_in_ready_high", 32'(in_ready), 32'd1);

        // Directed cases.
        do_req(8'd0, 8'd5, 8'd1, 0, 0, 1'b0);
        do_req(8'd250, 8'd8, 8'd2, 0, 1, 1'b0);
        do_req(8'd7, 8'd0, 8'd3, 0, 0, 1'b0);
        do_req(8'd1, 8'd4, 8'd3, 2, 0, 1'b0);
        do_req(8'd200, 8'd3, 8'hFF, 1, 2, 1'b0);

        // Completion stalled with a competing request pending.
        do_req(8'd20, 8'd3, 8'd5, 0, 3, 1'b1);
        do_req(8'd100, 8'd2, 8'd1, 0, 0, 1'b0);

        // Mid-stream reset aborts; a fresh request then runs normally.
        wait_accept(8'd0, 8'd6, 8'd1, acc);
        sOut_ready = 1'b1;
        for (int unsigned i = 0; i < 2; i++) begin
            check("pre_rst_elem", 32'(sOut), i);
            tick();
        end
        #2;
        nrst = 1'b0;
        #1;
        check("abort_sout_valid", 32'(sOut_valid), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        sOut_ready = 1'b0;
        @(posedge clk);
        #3;
        nrst = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_no_elem", 32'(sOut_valid), 32'd0);
        check("post_rst_no_cpl", 32'(out_valid), 32'd0);
        do_req(8'd9, 8'd2, 8'd1, 0, 0, 1'b0);

        // Maximum count.
        do_req(8'd3, 8'd255, 8'd7, 0, 0, 1'b0);

        // Random requests with random back-pressure and completion delay.
        for (int k = 0; k < 12; k++) begin
            do_req(8'($urandom_range(0, 255)), 8'($urandom_range(0, 12)),
                   8'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_range_src.md
Name: stream_range_src

Overview:
- Stream producer: the transmitter counterpart to stream-consuming blocks such as map kernels.
- Accepts one sync-handshaked request carrying start, count and step.
- Emits `count` elements on a valid/ready stream: start, start+step, start+2*step, …
- Then raises a completion handshake carrying the next (unemitted) value.
- Sits in front of generated stream kernels, replacing hand-driven stimulus.

Parameters:
- N, 8, data width of start, step and stream elements (matches `intN`).
- CW, 8, width of count / remaining-element counter.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request ready.
- in_start  in  N  first element value.
- in_count  in  CW  number of elements to emit (0 allowed).
- in_step  in  N  increment between elements.
- sOut  out  N  stream element.
- sOut_valid  out  1  stream element valid.
- sOut_ready  in  1  downstream accepts element.
- out_valid  out  1  completion valid.
- out_ready  in  1  completion accepted.
- out_next  out  N  start + count*step mod 2^N.

Behaviour:
- Reset (nrst low, async):
  - state=IDLE; sOut=0, sOut_valid=0, out_valid=0, out_next=0, in_ready=0.
  - in_ready rises the first clk edge after nrst deasserts.
- Reset mid-stream aborts immediately: no further elements, no completion.
- All outputs are registered.
- FSM states:
  - IDLE: in_ready=1.
    - On in_valid&in_ready: latch cur=in_start, rem=in_count, step=in_step; in_ready<=0.
    - If in_count==0 -> DONE with out_next=in_start.
    - Else -> RUN with sOut<=in_start, sOut_valid<=1.
  - RUN: sOut_valid=1, sOut holds cur.
    - Element transfers on the edge where sOut_valid&sOut_ready; then cur<=cur+step (mod 2^N), rem<=rem-1.
    - If rem==1 at transfer: sOut_valid<=0, out_next<=cur+step, out_valid<=1 -> DONE.
    - If sOut_ready is low: sOut and sOut_valid hold stable (no change while valid&!ready).
  - DONE: out_valid=1, out_next stable.
    - On out_ready: out_valid<=0, in_ready<=1 -> IDLE.
- Latency:
  - First element is valid the cycle after request acceptance.
  - With sOut_ready held high, one element per cycle.
  - out_valid rises the cycle after the last transfer.
  - count==0: out_valid rises the cycle after acceptance.
- Arithmetic: N-bit wrap-around, no saturation. Step is treated as unsigned; negative steps via two's complement wrap.
- in_valid during RUN/DONE is ignored (in_ready=0); the request must be held by the sender until accepted.
- count = 2^CW-1 is supported; the counter never underflows (DONE is entered at rem==1).
- A new request is accepted no earlier than the cycle after the completion handshake; there is no overlap.

Decomposition:
- Shared package holds:
  - state encoding localparams S_IDLE=0, S_RUN=1, S_DONE=2;
  - default widths N and CW.
- One natural sub-module: stream_reg_out. It is the output register stage for the (sOut, sOut_valid) pair with hold-on-stall; it is reusable by other stream producers.
- FSM and counters stay in the top module.

Test Plan:
- Request start=0, count=5, step=1, sOut_ready=1 -> sOut 0,1,2,3,4 on 5 consecutive cycles starting 1 cycle after accept; then out_valid=1, out_next=5.
- start=250, count=8, step=2 -> sOut 250,252,254,0,2,4,6,8 (wrap); out_next=10.
- count=0, start=7 -> no sOut_valid ever; out_valid=1 one cycle after accept, out_next=7.
- start=1, count=4, step=3 with sOut_ready toggling 1,0,0,1,0,1,1 -> sOut 1,4,7,10 each held stable while stalled; exactly 4 transfers; out_next=13.
- Mid-RUN nrst pulse (after 2 of 6 elements) -> sOut_valid and out_valid drop immediately; in_ready=1 the cycle after release; a fresh request (start=9, count=2, step=1) yields 9,10 and out_next=11.
- out_ready held low 3 cycles in DONE -> out_valid and out_next held; a second in_valid during that time is not accepted until after the completion handshake.
